// File: rtl/seq_alu.sv
// Registered ALU with Start/Done handshake: single-cycle logic/arith/shift ops
// and an iterative shift-add multiplier that holds Busy while it runs.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             LT,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW-1:0]     CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0]     CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] A_ZERO   = {(2*WIDTH){1'b0}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               last_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [SHW-1:0]     cnt_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     dif_s;
    logic [WIDTH-1:0]   res_s;
    logic               cy_s;

    logic [WIDTH-1:0]   out_r;
    logic               zero_r;
    logic               lt_r;
    logic               carry_r;
    logic               busy_r;
    logic               done_r;

    // A request is only taken when no multiply is iterating.
    assign accept_s  = Start && (state_r != ST_MUL);
    assign last_s    = (state_r == ST_MUL) && (cnt_r == CNT_LAST);
    assign acc_nxt_s = acc_r + (mplier_r[0] ? mcand_r : A_ZERO);

    // Next-state logic for the IDLE/MUL/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = (OP == OP_MUL) ? ST_MUL : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Single-cycle result and carry/borrow for the non-multiply ops.
    always_comb begin
        sum_s = {1'b0, InputA} + {1'b0, InputB};
        dif_s = {1'b0, InputA} - {1'b0, InputB};
        res_s = W_ZERO;
        cy_s  = 1'b0;
        case (OP)
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                cy_s  = sum_s[WIDTH];
            end
            OP_SUB: begin
                res_s = dif_s[WIDTH-1:0];
                cy_s  = dif_s[WIDTH];
            end
            OP_AND:  res_s = InputA & InputB;
            OP_OR:   res_s = InputA | InputB;
            OP_XOR:  res_s = InputA ^ InputB;
            OP_SHL:  res_s = InputA << InputB[SHW-1:0];
            OP_SHR:  res_s = InputA >> InputB[SHW-1:0];
            OP_MUL:  res_s = W_ZERO;
            default: res_s = W_ZERO;
        endcase
    end

    // State register with Busy/Done decoded from the next state so both are registered.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_MUL);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand latch, multiplier iteration and result/flag registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            a_r      <= W_ZERO;
            b_r      <= W_ZERO;
            acc_r    <= A_ZERO;
            mcand_r  <= A_ZERO;
            mplier_r <= W_ZERO;
            cnt_r    <= {SHW{1'b0}};
            out_r    <= W_ZERO;
            zero_r   <= 1'b0;
            lt_r     <= 1'b0;
            carry_r  <= 1'b0;
        end else if (accept_s) begin
            a_r <= InputA;
            b_r <= InputB;
            if (OP == OP_MUL) begin
                acc_r    <= A_ZERO;
                mcand_r  <= {W_ZERO, InputA};
                mplier_r <= InputB;
                cnt_r    <= {SHW{1'b0}};
            end else begin
                out_r   <= res_s;
                zero_r  <= (res_s == W_ZERO);
                lt_r    <= (InputA < InputB);
                carry_r <= cy_s;
            end
        end else if (state_r == ST_MUL) begin
            // One multiplier bit per cycle; the final sum is taken straight from the adder.
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_s) begin
                out_r   <= acc_nxt_s[WIDTH-1:0];
                zero_r  <= (acc_nxt_s[WIDTH-1:0] == W_ZERO);
                lt_r    <= (a_r < b_r);
                carry_r <= |acc_nxt_s[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign Out   = out_r;
    assign Zero  = zero_r;
    assign LT    = lt_r;
    assign Carry = carry_r;
    assign Busy  = busy_r;
    assign Done  = done_r;

endmodule
